// File: rtl/sqvl_dac_pkg.sv
// Shared types and constants for the square-wave DAC SPI serialiser.
package sqvl_dac_pkg;

  // SETUP and SHIFT both have bit 0 set, so SYNC_n decodes from one flop and cannot glitch.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SETUP = 2'b01,
    SHIFT = 2'b11,
    GAP   = 2'b10
  } state_t;

  localparam int FRAME_BITS = 16;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  localparam int SETUP_HALVES = 1;
  localparam int GAP_HALVES   = 3;

  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [1:0] pd, input logic [11:0] dat);
    return {2'b00, pd, dat};
  endfunction

endpackage

// File: rtl/sqvl_dac_tick.sv
// Half-period divider: one-cycle tick every CLK_DIV cycles, restarted by a synchronous clear.
module sqvl_dac_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (clr || tick) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/sqvl_dac_spi.sv
// Serialises 12-bit voltage words into 16-bit DAC7512-style SPI frames (SCLK idles high, DAC samples on fall).
// Optional one-deep pending buffer for loads arriving while busy: define SQVL_DAC_PEND_EN.
module sqvl_dac_spi
  import sqvl_dac_pkg::*;
#(
  parameter int         CLK_DIV = 4,
  parameter logic [1:0] PD_MODE = PD_NORMAL
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [11:0] Din,
  input  logic        Load,
  output logic        Busy,
  output logic        Done,
  output logic        SCLK,
  output logic        SYNC_n,
  output logic        SDATA
);

  localparam logic [4:0] SETUP_LAST = 5'(SETUP_HALVES - 1);
  localparam logic [4:0] SHIFT_LAST = 5'(2 * FRAME_BITS - 1);
  localparam logic [4:0] SHIFT_STOP = 5'(2 * FRAME_BITS - 2);
  localparam logic [4:0] GAP_LAST   = 5'(GAP_HALVES - 1);

  state_t                state;
  state_t                state_nxt;
  logic                  tick;
  logic                  clr;
  logic                  last_half;
  logic                  phase_end;
  logic                  start;
  logic                  reload;
  logic [4:0]            halves;
  logic [FRAME_BITS-1:0] shreg;
  logic [11:0]           load_dat;
  logic                  sclk_q;
  logic                  done_q;

  sqvl_dac_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (Clock),
    .rst  (Reset),
    .clr  (clr),
    .tick (tick)
  );

`ifdef SQVL_DAC_PEND_EN
  logic        pend_vld;
  logic [11:0] pend_dat;

  assign reload   = (state == GAP) && phase_end && pend_vld;
  assign load_dat = (state == GAP) ? pend_dat : Din;

  // A load landing on the transfer cycle re-arms the buffer for the frame after.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pend_vld <= 1'b0;
      pend_dat <= 12'd0;
    end else begin
      if (reload) begin
        pend_vld <= 1'b0;
      end
      if (Load && (state != IDLE)) begin
        pend_vld <= 1'b1;
        pend_dat <= Din;
      end
    end
  end
`else
  assign reload   = 1'b0;
  assign load_dat = Din;
`endif

  assign start = (state == IDLE) && Load;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    last_half = 1'b0;
    case (state)
      SETUP:   last_half = (halves == SETUP_LAST);
      SHIFT:   last_half = (halves == SHIFT_LAST);
      GAP:     last_half = (halves == GAP_LAST);
      default: last_half = 1'b0;
    endcase
    phase_end = tick && last_half;

    state_nxt = state;
    case (state)
      IDLE:    if (Load)      state_nxt = SETUP;
      SETUP:   if (phase_end) state_nxt = SHIFT;
      SHIFT:   if (phase_end) state_nxt = GAP;
      GAP:     if (phase_end) state_nxt = reload ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
    clr = (state_nxt != state);
  end

  // halves counts divider ticks within the current state; in SHIFT, odd ticks are SCLK rises.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      halves <= 5'd0;
      sclk_q <= 1'b1;
      shreg  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == SHIFT) && phase_end;

      if (clr) begin
        halves <= 5'd0;
      end else if (tick) begin
        halves <= halves + 5'd1;
      end

      if ((state == SETUP) && phase_end) begin
        sclk_q <= 1'b0;
      end else if ((state == SHIFT) && tick && !phase_end) begin
        sclk_q <= ~sclk_q;
      end

      if (start || reload) begin
        shreg <= frame_word(PD_MODE, load_dat);
      end else if ((state == SHIFT) && tick && !sclk_q && (halves != SHIFT_STOP)) begin
        shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    Busy   = (state != IDLE);
    SYNC_n = ~state[0];
    SDATA  = state[0] & shreg[FRAME_BITS-1];
    SCLK   = sclk_q;
    Done   = done_q;
  end

endmodule
